// File: rtl/game_controller.sv
// game_controller: ball-and-paddle game engine on a 640x480 playfield.
// Define GAME_CPU_EN to include CPU paddle control (modes 01 and 10).
module game_controller #(
    parameter int TICK_DIV    = 100000,
    parameter int SERVE_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    input  logic [1:0] mode,
    input  logic [1:0] max_score,
    input  logic       ball_speed,
    input  logic       serve_type,
    input  logic       angle,
    input  logic       bat_size,
    input  logic       serve,
    input  logic       start,
    output logic       p1_win,
    output logic       p2_win,
    output logic       turn,
    output logic       start_state,
    output logic       hit,
    output logic       wall,
    output logic       goal,
    output logic [1:0] game_mode,
    output logic [4:0] score1,
    output logic [4:0] score2,
    output logic [9:0] p1_yo,
    output logic [9:0] p2_yo,
    output logic [9:0] bx,
    output logic [9:0] by
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;
    logic          tick;
    logic          serve_q;
    logic          start_q;
    logic          serve_req;
    logic          dxp;
    logic          dyp;
    logic          dx_fast;
    logic          dy_big;
    logic [4:0]    target;

    logic [9:0] half;
    logic [9:0] lo;
    logic [9:0] hi;
    logic [9:0] lim;
    logic [9:0] p1_nxt;
    logic [9:0] p2_nxt;
    logic       cpu1;
    logic       cpu2;
    logic       srv_cpu;
    logic       practice;
    logic       launch_auto;
    logic       launch;
    logic       serve_rise;
    logic       start_rise;
    logic [4:0] sc1n;
    logic [4:0] sc2n;

    logic [9:0] dxv;
    logic [9:0] dyv;
    logic [9:0] nbx;
    logic [9:0] nby;
    logic       ndxp;
    logic       ndyp;
    logic       e_hit;
    logic       e_wall;
    logic       g1;
    logic       g2;

    function automatic logic [9:0] clamp(
        input logic [9:0] v,
        input logic [9:0] l,
        input logic [9:0] h
    );
        if (v < l)
            return l;
        else if (v > h)
            return h;
        else
            return v;
    endfunction

    function automatic logic [9:0] absdiff(
        input logic [9:0] a,
        input logic [9:0] b
    );
        return (a > b) ? a - b : b - a;
    endfunction

    // Step toward the target by at most 4 px; never overshoots.
    function automatic logic [9:0] chase(
        input logic [9:0] yo,
        input logic [9:0] tgt
    );
        logic [9:0] d;
        d = absdiff(yo, tgt);
        if (d > 10'd4)
            d = 10'd4;
        return (tgt > yo) ? yo + d : yo - d;
    endfunction

    assign tick        = (cnt == CW'(TICK_DIV - 1));
    assign start_state = (state == S_IDLE);
    assign practice    = (game_mode == 2'b11);
    assign serve_rise  = serve & ~serve_q;
    assign start_rise  = start & ~start_q;

`ifdef GAME_CPU_EN
    assign cpu1 = (game_mode == 2'b10);
    assign cpu2 = (game_mode == 2'b01) || (game_mode == 2'b10);
`else
    assign cpu1 = 1'b0;
    assign cpu2 = 1'b0;
`endif

    assign half   = bat_size ? 10'd48 : 10'd32;
    assign lo     = half;
    assign hi     = 10'd479 - half;
    assign lim    = half + 10'd4;
    assign p1_nxt = clamp(cpu1 ? chase(p1_yo, by) : p1_y, lo, hi);
    assign p2_nxt = clamp(cpu2 ? chase(p2_yo, by) : p2_y, lo, hi);

    assign srv_cpu     = turn ? cpu2 : cpu1;
    assign launch_auto = (scnt == SW'(SERVE_TICKS - 1));
    assign launch      = (serve_type && !srv_cpu) ? serve_req : launch_auto;

    assign sc1n = (score1 == 5'd31) ? 5'd31 : score1 + 5'd1;
    assign sc2n = (score2 == 5'd31) ? 5'd31 : score2 + 5'd1;

    always_comb begin
        dxv    = dx_fast ? 10'd4 : 10'd2;
        dyv    = dy_big ? 10'd2 : 10'd1;
        nbx    = dxp ? bx + dxv : ((bx > dxv) ? bx - dxv : 10'd0);
        nby    = dyp ? by + dyv : ((by > dyv) ? by - dyv : 10'd0);
        ndxp   = dxp;
        ndyp   = dyp;
        e_hit  = 1'b0;
        e_wall = 1'b0;
        g1     = 1'b0;
        g2     = 1'b0;
        if (nby <= 10'd4) begin
            nby    = 10'd4;
            ndyp   = 1'b1;
            e_wall = 1'b1;
        end else if (nby >= 10'd475) begin
            nby    = 10'd475;
            ndyp   = 1'b0;
            e_wall = 1'b1;
        end
        if (!dxp && nbx <= 10'd24 && absdiff(nby, p1_yo) <= lim) begin
            nbx   = 10'd24;
            ndxp  = 1'b1;
            e_hit = 1'b1;
        end else if (dxp && nbx >= 10'd615 &&
                     (practice || absdiff(nby, p2_yo) <= lim)) begin
            nbx  = 10'd615;
            ndxp = 1'b0;
            if (practice)
                e_wall = 1'b1;
            else
                e_hit = 1'b1;
        end
        if (nbx <= 10'd4)
            g2 = 1'b1;
        else if (nbx >= 10'd635)
            g1 = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            scnt      <= '0;
            serve_q   <= 1'b0;
            start_q   <= 1'b0;
            serve_req <= 1'b0;
            dxp       <= 1'b1;
            dyp       <= 1'b1;
            dx_fast   <= 1'b0;
            dy_big    <= 1'b0;
            target    <= 5'd3;
            game_mode <= 2'b00;
            score1    <= 5'd0;
            score2    <= 5'd0;
            turn      <= 1'b0;
            p1_win    <= 1'b0;
            p2_win    <= 1'b0;
            hit       <= 1'b0;
            wall      <= 1'b0;
            goal      <= 1'b0;
            p1_yo     <= 10'd240;
            p2_yo     <= 10'd240;
            bx        <= 10'd320;
            by        <= 10'd240;
        end else begin
            cnt     <= tick ? '0 : cnt + CW'(1);
            serve_q <= serve;
            start_q <= start;
            hit     <= 1'b0;
            wall    <= 1'b0;
            goal    <= 1'b0;
            if (tick && state != S_OVER) begin
                p1_yo <= p1_nxt;
                p2_yo <= p2_nxt;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        game_mode <= mode;
                        unique case (max_score)
                            2'b00: target <= 5'd3;
                            2'b01: target <= 5'd5;
                            2'b10: target <= 5'd10;
                            2'b11: target <= 5'd15;
                        endcase
                        score1    <= 5'd0;
                        score2    <= 5'd0;
                        turn      <= 1'b0;
                        scnt      <= '0;
                        serve_req <= 1'b0;
                        bx        <= 10'd32;
                        by        <= p1_yo;
                        state     <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (serve_rise && !(tick && launch))
                        serve_req <= 1'b1;
                    if (tick) begin
                        bx <= turn ? 10'd607 : 10'd32;
                        by <= turn ? p2_nxt : p1_nxt;
                        if (launch) begin
                            dxp       <= ~turn;
                            dyp       <= 1'b1;
                            dx_fast   <= ball_speed;
                            dy_big    <= angle;
                            serve_req <= 1'b0;
                            scnt      <= '0;
                            state     <= S_PLAY;
                        end else if (!launch_auto) begin
                            scnt <= scnt + SW'(1);
                        end
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        bx   <= nbx;
                        by   <= nby;
                        dxp  <= ndxp;
                        dyp  <= ndyp;
                        hit  <= e_hit;
                        wall <= e_wall;
                        goal <= g1 | g2;
                        if (g1 || g2) begin
                            // The conceding player serves next.
                            turn      <= g1;
                            scnt      <= '0;
                            serve_req <= 1'b0;
                            if (g1)
                                score1 <= sc1n;
                            else
                                score2 <= sc2n;
                            if (g1 && sc1n == target) begin
                                p1_win <= 1'b1;
                                state  <= S_OVER;
                            end else if (g2 && sc2n == target) begin
                                p2_win <= 1'b1;
                                state  <= S_OVER;
                            end else begin
                                bx    <= g1 ? 10'd607 : 10'd32;
                                by    <= g1 ? p2_nxt : p1_nxt;
                                state <= S_SERVE;
                            end
                        end
                    end
                end
                S_OVER: begin
                    if (start_rise) begin
                        p1_win <= 1'b0;
                        p2_win <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed checks of serve, walls, paddles, goals,
// game over and (build-dependent) CPU paddle tracking.
module tb_game_controller;

`ifdef GAME_CPU_EN
    localparam bit CPU = 1'b1;
`else
    localparam bit CPU = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [9:0] p1_y;
    logic [9:0] p2_y;
    logic [1:0] mode;
    logic [1:0] max_score;
    logic       ball_speed;
    logic       serve_type;
    logic       angle;
    logic       bat_size;
    logic       serve;
    logic       start;
    logic       p1_win;
    logic       p2_win;
    logic       turn;
    logic       start_state;
    logic       hit;
    logic       wall;
    logic       goal;
    logic [1:0] game_mode;
    logic [4:0] score1;
    logic [4:0] score2;
    logic [9:0] p1_yo;
    logic [9:0] p2_yo;
    logic [9:0] bx;
    logic [9:0] by;

    int n_cmp;
    int n_bad;
    int cyc;

    game_controller #(
        .TICK_DIV   (4),
        .SERVE_TICKS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .mode       (mode),
        .max_score  (max_score),
        .ball_speed (ball_speed),
        .serve_type (serve_type),
        .angle      (angle),
        .bat_size   (bat_size),
        .serve      (serve),
        .start      (start),
        .p1_win     (p1_win),
        .p2_win     (p2_win),
        .turn       (turn),
        .start_state(start_state),
        .hit        (hit),
        .wall       (wall),
        .goal       (goal),
        .game_mode  (game_mode),
        .score1     (score1),
        .score2     (score2),
        .p1_yo      (p1_yo),
        .p2_yo      (p2_yo),
        .bx         (bx),
        .by         (by)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks fall on every 4th posedge after reset release.
    task automatic adv_to(input int t);
        while (cyc < 4 * t) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic one_clk();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic release_and_start();
        @(negedge clk);
        rst   = 1'b1;
        cyc   = 0;
        start = 1'b1;
        one_clk();
        start = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        cyc        = 0;
        rst        = 1'b1;
        p1_y       = 10'd240;
        p2_y       = 10'd240;
        mode       = 2'b00;
        max_score  = 2'b00;
        ball_speed = 1'b0;
        serve_type = 1'b0;
        angle      = 1'b0;
        bat_size   = 1'b0;
        serve      = 1'b0;
        start      = 1'b0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_bx", bx, 320);
        chk("rst_by", by, 240);
        chk("rst_p1yo", p1_yo, 240);
        chk("rst_p2yo", p2_yo, 240);
        chk("rst_score1", score1, 0);
        chk("rst_score2", score2, 0);
        chk("rst_start_state", start_state, 1);
        chk("rst_turn", turn, 0);
        chk("rst_game_mode", game_mode, 0);
        chk("rst_pulses", {hit, wall, goal, p1_win, p2_win}, 0);

        release_and_start();
        chk("a_left_idle", start_state, 0);
        chk("a_park_bx", bx, 32);
        chk("a_park_by", by, 240);
        adv_to(3);
        chk("a_launch_bx", bx, 32);
        adv_to(4);
        chk("a_step1_bx", bx, 34);
        chk("a_step1_by", by, 241);
        adv_to(5);
        chk("a_step2_bx", bx, 36);
        chk("a_step2_by", by, 242);

        rst = 1'b0;
        #1;
        chk("midrst_bx", bx, 320);
        chk("midrst_by", by, 240);
        chk("midrst_idle", start_state, 1);

        p1_y  = 10'd447;
        p2_y  = 10'd0;
        angle = 1'b1;
        release_and_start();
        adv_to(1);
        chk("b_p2_clamp", p2_yo, 32);
        chk("b_park_by", by, 447);
        adv_to(17);
        chk("b_bottom_by", by, 475);
        chk("b_bottom_wall", wall, 1);
        chk("b_bottom_bx", bx, 60);
        adv_to(252);
        chk("b_by5", by, 5);
        chk("b_bx530", bx, 530);
        adv_to(253);
        chk("b_top_by", by, 4);
        chk("b_top_wall", wall, 1);
        one_clk();
        chk("b_wall_pulse_end", wall, 0);
        adv_to(254);
        chk("b_dy_pos", by, 6);
        adv_to(295);
        chk("b_miss_bx", bx, 616);
        chk("b_miss_hit", hit, 0);
        adv_to(305);
        chk("b_goal", goal, 1);
        chk("b_score1", score1, 1);
        chk("b_score2", score2, 0);
        chk("b_turn", turn, 1);
        chk("b_repark_bx", bx, 607);
        chk("b_repark_by", by, 32);

        p2_y       = 10'd240;
        p1_y       = 10'd386;
        ball_speed = 1'b1;
        angle      = 1'b0;
        for (int r = 1; r <= 2; r++) begin
            int t0;
            t0 = 305 + 302 * (r - 1);
            adv_to(t0 + 3);
            chk("c_launch_bx", bx, 607);
            chk("c_launch_by", by, 240);
            adv_to(t0 + 149);
            chk("c_hit", hit, 1);
            chk("c_hit_bx", bx, 24);
            chk("c_hit_by", by, 386);
            adv_to(t0 + 302);
            chk("c_goal", goal, 1);
            chk("c_score1", score1, r + 1);
        end
        chk("over_p1_win", p1_win, 1);
        chk("over_p2_win", p2_win, 0);
        chk("over_not_idle", start_state, 0);
        adv_to(930);
        chk("over_hold_score", score1, 3);
        chk("over_hold_win", p1_win, 1);
        start = 1'b1;
        one_clk();
        start = 1'b0;
        chk("restart_idle", start_state, 1);
        chk("restart_win_clr", p1_win, 0);
        chk("restart_score_kept", score1, 3);

        rst        = 1'b0;
        mode       = 2'b01;
        bat_size   = 1'b1;
        p1_y       = 10'd479;
        p2_y       = 10'd0;
        angle      = 1'b1;
        ball_speed = 1'b0;
        serve_type = 1'b1;
        release_and_start();
        chk("d_game_mode", game_mode, 1);
        adv_to(1);
        chk("d_p1_clamp", p1_yo, 431);
        chk("d_park_by", by, 431);
        chk("d_p2_t1", p2_yo, CPU ? 240 : 48);
        adv_to(2);
        chk("d_p2_t2", p2_yo, CPU ? 244 : 48);
        adv_to(3);
        chk("d_p2_t3", p2_yo, CPU ? 248 : 48);
        adv_to(50);
        chk("d_manual_wait", bx, 32);
        chk("d_p2_t50", p2_yo, CPU ? 431 : 48);
        serve = 1'b1;
        one_clk();
        one_clk();
        serve = 1'b0;
        adv_to(51);
        chk("d_launch_bx", bx, 32);
        adv_to(52);
        chk("d_step_bx", bx, 34);
        chk("d_step_by", by, 433);
        adv_to(73);
        chk("d_wall_by", by, 475);
        chk("d_wall", wall, 1);
        chk("d_p2_clamp", p2_yo, CPU ? 431 : 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_controller.md
# game_controller

Core game engine for the ball-and-paddle game: tracks paddle positions, ball position and velocity, collisions, scores and winner on a 640x480 playfield. Sits between the input/settings logic (paddle positions, switches, buttons) and the video renderer, which draws from `bx`, `by`, `p1_yo`, `p2_yo` and the score and status outputs.

## Interface
- `TICK_DIV`, 100000: clock cycles per game tick. All motion happens on ticks.
- `SERVE_TICKS`, 60: ticks of delay before an automatic serve.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `p1_y`, `p2_y`  in  10  requested paddle centre y.
- `mode`  in  2  00 two-player; 01 player vs CPU (p2 is CPU); 10 CPU vs CPU; 11 practice (right side is a solid wall).
- `max_score`  in  2  points to win: 00=3, 01=5, 10=10, 11=15.
- `ball_speed`  in  1  ball x step per tick: 0=2 px, 1=4 px.
- `serve_type`  in  1  0 automatic serve, 1 manual serve.
- `angle`  in  1  ball y step per tick: 0=1 px, 1=2 px.
- `bat_size`  in  1  paddle half-height: 0=32, 1=48.
- `serve`  in  1  manual serve request (rising edge).
- `start`  in  1  start request (level in IDLE, rising edge in GAMEOVER).
- `p1_win`, `p2_win`  out  1  winner flags, held in GAMEOVER.
- `turn`  out  1  current server: 0 = p1, 1 = p2.
- `start_state`  out  1  high while in IDLE.
- `hit`, `wall`, `goal`  out  1  one-clock event pulses.
- `game_mode`  out  2  mode latched for the current game.
- `score1`, `score2`  out  5  player scores.
- `p1_yo`, `p2_yo`  out  10  clamped paddle centres.
- `bx`, `by`  out  10  ball centre.

## Operation
- The tick counter counts 0..TICK_DIV-1; a tick is the cycle where it equals TICK_DIV-1.
- States: IDLE, SERVE, PLAY, GAMEOVER.
- IDLE: while `start`=1, latch `mode` into `game_mode` and the target from `max_score`, clear the scores, set `turn`=0, then go to SERVE.
- SERVE: the ball is parked at the server's paddle.
  - p1 serving: `bx`=32, `by`=`p1_yo`.
  - p2 serving: `bx`=607, `by`=`p2_yo`.
  - Sample `ball_speed` and `angle` here. The ball launches toward the opponent with dy positive.
  - Launch condition: `serve_type`=0, after SERVE_TICKS ticks; `serve_type`=1, on the next tick after a `serve` rising edge.
  - A CPU-controlled server always auto-serves.
- PLAY, each tick: step `bx` by ±dx and `by` by ±dy. Evaluate in this order:
  - Wall: new `by` ≤ 4 → `by`=4, dy becomes positive, `wall` pulses. New `by` ≥ 475 → `by`=475, dy becomes negative, `wall` pulses.
  - Left paddle: moving left, new `bx` ≤ 24 and |`by`−`p1_yo`| ≤ half+4 → `bx`=24, dx becomes positive, `hit` pulses.
  - Right paddle: moving right, new `bx` ≥ 615 and |`by`−`p2_yo`| ≤ half+4 → `bx`=615, dx becomes negative, `hit` pulses. In practice mode the right side always reflects, with `wall` asserted instead of `hit`.
  - Goal: new `bx` ≤ 4 → `score2`+1, `turn`=0. New `bx` ≥ 635 → `score1`+1, `turn`=1. In both cases `goal` pulses; the player who conceded serves next.
  - After a goal: if the new score equals the target, go to GAMEOVER and set the matching win flag; otherwise go to SERVE.
- Paddles, every tick:
  - Human paddle: `pN_yo` = `pN_y` clamped to [half, 479−half].
  - CPU paddle: moves toward `by` by at most 4 px per tick, with the same clamp.
  - `bat_size` applies immediately.
- GAMEOVER: outputs hold. A rising edge of `start` returns to IDLE and clears the win flags.
- Arithmetic: 10-bit unsigned. Clamp before any subtraction so nothing underflows. Scores saturate at 31.
- Simultaneous events: wall and paddle handling may both occur on the same tick. A goal overrides a paddle miss.

## Timing
- Reset (async, `rst`=0):
  - State IDLE, tick counter 0.
  - `bx`=320, `by`=240, `p1_yo`=`p2_yo`=240.
  - Scores 0, `turn`=0, `game_mode`=00.
  - All flags and pulses 0; `start_state`=1.
- Registered outputs update on the tick cycle; event pulses are high for exactly that one clock.
- IDLE→SERVE takes one clock. SERVE→PLAY happens on a tick. A goal moves to SERVE or GAMEOVER on the same tick edge.
- Reset asserted mid-game returns everything to the reset values immediately.

## Configuration
- `GAME_CPU_EN` defined: the CPU paddle logic is included.
- `GAME_CPU_EN` undefined: modes 01 and 10 behave as 00, and `game_mode` still reports the latched value.

## Test plan
- Reset with `TICK_DIV`=4 → `bx`=320, `by`=240, scores 0, `start_state`=1; after `rst`=1 and `start`=1 → the FSM leaves IDLE and the ball parks at (32, 240).
- Auto serve with `ball_speed`=0, `angle`=0 → after SERVE_TICKS ticks `bx` increases by 2 and `by` by 1 per tick.
- Ball at `by`=5 moving up with dy=2 → `by`=4, dy becomes positive, a one-clock `wall` pulse.
- `p2_y`=0, ball arriving at the right side near y=240 → no hit; `bx` ≥ 635 gives `score1`=1, a `goal` pulse and `turn`=1.
- `max_score`=00 and p1 scores three times → GAMEOVER with `p1_win`=1; scores hold until a `start` rising edge.
- `mode`=01 with `GAME_CPU_EN` → `p2_yo` tracks `by` at ≤4 px per tick; with `bat_size`=1 the clamp range is [48, 431].
